bcd_to_signed_bin: RTL

Sequential BCD-to-binary decoder: the input-side counterpart of the ALU's binary-to-BCD display encoder. It takes a sign flag and three BCD digits, as entered on the board's digit switches or keypad, and converts them with a reverse double-dabble (shift-right / subtract-3) over 10 cycles. It delivers an 8-bit two's-complement value with range flags, so the result can be range-checked before it drives the ALU's 4-bit signed operands.

---
 rtl/bcd_to_signed_bin.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/bcd_to_signed_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_signed_bin
//
// Sequential three-digit BCD to 8-bit two's-complement decoder. It is the
// input-side partner of the binary-to-BCD display encoder. A sign flag and
// three BCD digits are sampled on start. The magnitude is recovered with a
// reverse double-dabble (shift right, then subtract 3 from any BCD nibble
// of 8 or more) over 10 cycles. The result is then saturated to -128..127
// and flagged so it can be range-checked before it feeds a 4-bit signed ALU
// operand.
//
// Ports
//   clk_i        : clock, all state changes on the rising edge
//   rst_i        : asynchronous active-high reset
//   start_i      : conversion request, only honoured in IDLE
//   dau_i        : sign of the entered number (1 = negative), sampled with start
//   bcd_hund_i   : hundreds digit, sampled with start
//   bcd_tens_i   : tens digit, sampled with start
//   bcd_unit_i   : units digit, sampled with start
//   busy_o       : conversion in progress
//   done_o       : one-cycle pulse when the result outputs update
//   value_o      : signed result (two's complement)
//   overflow_o   : magnitude outside -128..127, value saturated
//   invalid_o    : a digit was greater than 9, value forced to 0
//   fits4_o      : value lies in -8..7
// -----------------------------------------------------------------------------
module bcd_to_signed_bin (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       dau_i,
  input  logic [3:0] bcd_hund_i,
  input  logic [3:0] bcd_tens_i,
  input  logic [3:0] bcd_unit_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] value_o,
  output logic       overflow_o,
  output logic       invalid_o,
  output logic       fits4_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  bin_q, bin_d;
  logic [3:0]  iter_q, iter_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  value_q, value_d;
  logic        ovf_q, ovf_d;
  logic        inv_q, inv_d;
  logic        fits4_q, fits4_d;

  logic [21:0] step_s;
  logic        digit_bad_s;
  logic [7:0]  res_value_s;
  logic        res_ovf_s;

  // One reverse double-dabble iteration on the {bcd, bin} register.
  function automatic logic [21:0] dabble_step(input logic [21:0] r);
    logic [21:0] s;
    s = r >> 5'd1;
    for (int i = 0; i < 3; i++) begin
      if (s[10 + 4*i +: 4] >= 4'd8) begin
        s[10 + 4*i +: 4] = s[10 + 4*i +: 4] - 4'd3;
      end else begin
        s[10 + 4*i +: 4] = s[10 + 4*i +: 4];
      end
    end
    return s;
  endfunction

  // A signed byte fits in 4 bits when bits 7..3 are all copies of the sign.
  function automatic logic fits_in_4(input logic [7:0] v);
    return (v[7:3] == 5'b00000) || (v[7:3] == 5'b11111);
  endfunction

  assign step_s      = dabble_step({bcd_q, bin_q});
  assign digit_bad_s = (bcd_hund_i > 4'd9) || (bcd_tens_i > 4'd9) ||
                       (bcd_unit_i > 4'd9);

  // Final signed value and saturation from the converted magnitude.
  always_comb begin
    res_value_s = 8'h00;
    res_ovf_s   = 1'b0;
    if (err_q) begin
      res_value_s = 8'h00;
      res_ovf_s   = 1'b0;
    end else if (!neg_q) begin
      if (bin_q > 10'd127) begin
        res_value_s = 8'h7F;
        res_ovf_s   = 1'b1;
      end else begin
        res_value_s = bin_q[7:0];
      end
    end else begin
      // -128 is reachable on the negative side; 128 negates to 8'h80.
      if (bin_q > 10'd128) begin
        res_value_s = 8'h80;
        res_ovf_s   = 1'b1;
      end else begin
        res_value_s = 8'h00 - bin_q[7:0];
      end
    end
  end

  // Next-state and next-output logic of the conversion FSM.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    iter_d  = iter_q;
    neg_d   = neg_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    value_d = value_q;
    ovf_d   = ovf_q;
    inv_d   = inv_q;
    fits4_d = fits4_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bcd_d  = {bcd_hund_i, bcd_tens_i, bcd_unit_i};
          bin_d  = 10'd0;
          neg_d  = dau_i;
          err_d  = digit_bad_s;
          iter_d = 4'd0;
          busy_d = 1'b1;
          if (digit_bad_s) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_CONV;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        {bcd_d, bin_d} = step_s;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_FIN: begin
        value_d = res_value_s;
        ovf_d   = res_ovf_s;
        inv_d   = err_q;
        fits4_d = fits_in_4(res_value_s);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      bcd_q   <= 12'd0;
      bin_q   <= 10'd0;
      iter_q  <= 4'd0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      value_q <= 8'h00;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
      fits4_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      iter_q  <= iter_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      inv_q   <= inv_d;
      fits4_q <= fits4_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign value_o    = value_q;
  assign overflow_o = ovf_q;
  assign invalid_o  = inv_q;
  assign fits4_o    = fits4_q;

endmodule
